// File: rtl/core_pipe_stage_pkg.sv
// rtl/core_pipe_stage_pkg.sv - shared widths and bubble encodings for pipeline stage boundaries
package core_pipe_stage_pkg;

   localparam int OPERAND_WIDTH = 64;
   localparam int CPU_PC_SIZE   = 64;

   localparam int CTRL_W_ID  = 3;
   localparam int CTRL_W_EX  = 3;
   localparam int CTRL_W_MEM = 2;
   localparam int CTRL_W_WB  = 1;

   localparam logic [CTRL_W_ID-1:0]  CTRL_RST_ID  = '0;
   localparam logic [CTRL_W_EX-1:0]  CTRL_RST_EX  = '0;
   localparam logic [CTRL_W_MEM-1:0] CTRL_RST_MEM = '0;
   localparam logic [CTRL_W_WB-1:0]  CTRL_RST_WB  = '0;

   function automatic logic [1:0] entry_count(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

// File: rtl/core_pipe_slot.sv
// rtl/core_pipe_slot.sv - valid/data/ctrl holding register with clear and load enable
module core_pipe_slot #(
   parameter int                    DATA_WIDTH = 64,
   parameter int                    CTRL_WIDTH = 3,
   parameter logic [CTRL_WIDTH-1:0] CTRL_RST   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CTRL_WIDTH-1:0] ctrl_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;

   always_comb begin
      valid_d = valid_q;
      if (clr_i)       valid_d = 1'b0;
      else if (load_i) valid_d = valid_i;
   end

   // Payload only moves with a real beat; going empty or clearing leaves old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= CTRL_RST;
      end else begin
         valid_q <= valid_d;
         if (!clr_i && load_i && valid_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/core_pipe_stage.sv
// rtl/core_pipe_stage.sv - stage boundary register with flush; CORE_PIPE_STAGE_SKID_EN adds a skid entry
module core_pipe_stage
   import core_pipe_stage_pkg::*;
#(
   parameter int                    DATA_WIDTH = OPERAND_WIDTH,
   parameter int                    CTRL_WIDTH = CTRL_W_EX,
   parameter logic [CTRL_WIDTH-1:0] CTRL_RST   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CTRL_WIDTH-1:0] ctrl_o,
   output logic [1:0]            count_o
);

   logic                  out_valid;
   logic [CTRL_WIDTH-1:0] out_ctrl;
   logic                  out_adv;
   logic                  xfer_in;
   logic                  out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_d;

   assign out_adv = ~out_valid | ready_i;
   assign xfer_in = valid_i & ready_o;

`ifdef CORE_PIPE_STAGE_SKID_EN
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_data;
   logic [CTRL_WIDTH-1:0] skid_ctrl;
   logic                  skid_fill;

   // ready_o comes straight from a flop so back-pressure never chains combinationally.
   assign ready_o   = ~skid_valid;
   assign skid_fill = xfer_in & out_valid & ~ready_i;

   core_pipe_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH),
      .CTRL_RST   (CTRL_RST)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (flush_i),
      .load_i  (skid_fill | (skid_valid & out_adv)),
      .valid_i (skid_fill),
      .data_i  (data_i),
      .ctrl_i  (ctrl_i),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
   );

   assign out_valid_d = skid_valid | xfer_in;
   assign out_data_d  = skid_valid ? skid_data : data_i;
   assign out_ctrl_d  = skid_valid ? skid_ctrl : ctrl_i;
   assign count_o     = entry_count(out_valid, skid_valid);
`else
   assign ready_o     = out_adv;
   assign out_valid_d = xfer_in;
   assign out_data_d  = data_i;
   assign out_ctrl_d  = ctrl_i;
   assign count_o     = entry_count(out_valid, 1'b0);
`endif

   core_pipe_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH),
      .CTRL_RST   (CTRL_RST)
   ) u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (flush_i),
      .load_i  (out_adv),
      .valid_i (out_valid_d),
      .data_i  (out_data_d),
      .ctrl_i  (out_ctrl_d),
      .valid_o (out_valid),
      .data_o  (data_o),
      .ctrl_o  (out_ctrl)
   );

   // Bubbles must never look like a register-file or memory write downstream.
   assign valid_o = out_valid;
   assign ctrl_o  = out_valid ? out_ctrl : CTRL_RST;

endmodule

// File: tb/tb_core_pipe_stage.sv
// tb/tb_core_pipe_stage.sv - scoreboard bench for core_pipe_stage
module tb_core_pipe_stage;

   localparam int         DW    = 64;
   localparam int         CW    = 3;
   localparam logic [2:0] C_RST = 3'b101;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [DW-1:0] data_i = '0;
   logic [CW-1:0] ctrl_i = '0;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic [DW-1:0] data_o;
   logic [CW-1:0] ctrl_o;
   logic [1:0]    count_o;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW+CW-1:0] exp_q[$];

   core_pipe_stage #(
      .DATA_WIDTH (DW),
      .CTRL_WIDTH (CW),
      .CTRL_RST   (C_RST)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .ctrl_i  (ctrl_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .ctrl_o  (ctrl_o),
      .count_o (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted beats are queued in arrival order, departing beats are popped.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else if (flush_i) begin
         exp_q.delete();
      end else begin
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", {1'b1, data_o[62:0]}, 64'h0);
            end else begin
               logic [DW+CW-1:0] e;
               e = exp_q.pop_front();
               check("sb_data", data_o, e[DW+CW-1:CW]);
               check("sb_ctrl", {61'd0, ctrl_o}, {61'd0, e[CW-1:0]});
            end
         end
         if (valid_i && ready_o) exp_q.push_back({data_i, ctrl_i});
      end
   end

   initial begin
      // reset
      #12;
      check("rst_valid", {63'd0, valid_o}, 64'd0);
      check("rst_count", {62'd0, count_o}, 64'd0);
      check("rst_ctrl", {61'd0, ctrl_o}, {61'd0, C_RST});
      check("rst_data", data_o, 64'd0);
      rst_n = 1'b1;
      tick();
      check("rst_ready", {63'd0, ready_o}, 64'd1);

      // streaming 1..8
      ready_i = 1'b1;
      valid_i = 1'b1;
      ctrl_i  = 3'b010;
      for (int k = 1; k <= 8; k++) begin
         data_i = 64'(k);
         tick();
         check("stream_valid", {63'd0, valid_o}, 64'd1);
         check("stream_data", data_o, 64'(k));
         check("stream_count", {62'd0, count_o}, 64'd1);
         check("stream_ready", {63'd0, ready_o}, 64'd1);
      end
      valid_i = 1'b0;
      tick();
      check("drain_valid", {63'd0, valid_o}, 64'd0);
      check("drain_count", {62'd0, count_o}, 64'd0);

      // bubble mask
      valid_i = 1'b1;
      data_i  = 64'h9;
      ctrl_i  = 3'b111;
      tick();
      valid_i = 1'b0;
      check("mask_ctrl_live", {61'd0, ctrl_o}, 64'd7);
      tick();
      check("mask_valid", {63'd0, valid_o}, 64'd0);
      check("mask_ctrl_bubble", {61'd0, ctrl_o}, {61'd0, C_RST});
      ctrl_i = 3'b011;

`ifdef CORE_PIPE_STAGE_SKID_EN
      // back-pressure into the skid entry
      valid_i = 1'b1;
      data_i  = 64'hA;
      tick();
      ready_i = 1'b0;
      data_i  = 64'hB;
      tick();
      check("bp_count2", {62'd0, count_o}, 64'd2);
      check("bp_ready_low", {63'd0, ready_o}, 64'd0);
      check("bp_hold_a", data_o, 64'hA);
      data_i = 64'hC;
      tick();
      check("bp_still2", {62'd0, count_o}, 64'd2);
      check("bp_still_a", data_o, 64'hA);
      ready_i = 1'b1;
      tick();
      check("bp_out_b", data_o, 64'hB);
      check("bp_ready_back", {63'd0, ready_o}, 64'd1);
      tick();
      valid_i = 1'b0;
      check("bp_out_c", data_o, 64'hC);
      check("bp_count_c", {62'd0, count_o}, 64'd1);
      tick();
      check("bp_empty", {63'd0, valid_o}, 64'd0);

      // flush with two entries held and a beat D offered
      valid_i = 1'b1;
      data_i  = 64'h11;
      tick();
      ready_i = 1'b0;
      data_i  = 64'h22;
      tick();
      check("fl_pre_count", {62'd0, count_o}, 64'd2);
`else
      // back-pressure without skid: ready_o follows ready_i in the same cycle
      valid_i = 1'b1;
      data_i  = 64'hA;
      tick();
      valid_i = 1'b0;
      ready_i = 1'b0;
      #1;
      check("ns_ready_low", {63'd0, ready_o}, 64'd0);
      check("ns_count_hold", {62'd0, count_o}, 64'd1);
      tick();
      check("ns_hold_a", data_o, 64'hA);
      ready_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 64'hB;
      #1;
      check("ns_ready_high", {63'd0, ready_o}, 64'd1);
      tick();
      valid_i = 1'b0;
      check("ns_out_b", data_o, 64'hB);
      check("ns_count_1", {62'd0, count_o}, 64'd1);
      tick();
      check("ns_empty", {63'd0, valid_o}, 64'd0);

      // flush with one entry held and a beat D offered
      valid_i = 1'b1;
      data_i  = 64'h11;
      tick();
      ready_i = 1'b0;
      valid_i = 1'b0;
      #1;
      check("fl_pre_count", {62'd0, count_o}, 64'd1);
`endif
      flush_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 64'hD;
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      check("fl_valid", {63'd0, valid_o}, 64'd0);
      check("fl_count", {62'd0, count_o}, 64'd0);
      check("fl_ctrl", {61'd0, ctrl_o}, {61'd0, C_RST});
      check("fl_data_kept", data_o, 64'h11);
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("fl_no_d", {63'd0, valid_o}, 64'd0);
      end

      // asynchronous reset with entries held
      valid_i = 1'b1;
      data_i  = 64'h33;
      tick();
      ready_i = 1'b0;
      data_i  = 64'h44;
      tick();
      valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, valid_o}, 64'd0);
      check("arst_count", {62'd0, count_o}, 64'd0);
      check("arst_ctrl", {61'd0, ctrl_o}, {61'd0, C_RST});
      check("arst_data", data_o, 64'd0);
      #3;
      rst_n = 1'b1;
      tick();
      check("arst_ready", {63'd0, ready_o}, 64'd1);
      check("arst_stay_empty", {63'd0, valid_o}, 64'd0);

      tick();
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/core_pipe_stage.md
# core_pipe_stage

Parametrised pipeline boundary register: the successor to the fixed per-stage latch banks between IF/ID/EX/MEM/WB. It carries one opaque data bundle plus one control bundle across a stage with a valid/ready handshake, synchronous flush that turns the stage into a bubble, and an optional 2-entry skid buffer so that back-pressure never forms a combinational path through the pipeline. Instantiated once per stage boundary in the core; stage-specific packing of pc/instr/imm/alu/etc. happens in the instantiating stage.

## Interface
- DATA_WIDTH, 64: width of data bundle (pc, instr, operands, results; never cleared by flush)
- CTRL_WIDTH, 3: width of control bundle (reg_write, mem2reg, ...)
- CTRL_RST, 0: control value presented whenever the stage holds no valid entry (bubble encoding)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset; asynchronous and active-low
- flush_i  input  1  synchronous kill of all held entries and of the incoming beat
- valid_i  input  1  upstream beat valid
- ready_o  output  1  stage can accept a beat this cycle
- data_i  input  DATA_WIDTH  upstream data bundle
- ctrl_i  input  CTRL_WIDTH  upstream control bundle
- valid_o  output  1  downstream beat valid
- ready_i  input  1  downstream accepts beat
- data_o  output  DATA_WIDTH  held data bundle
- ctrl_o  output  CTRL_WIDTH  held control bundle, CTRL_RST when valid_o=0
- count_o  output  2  entries held (0..2; max 1 without skid)

## Operation
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i.
- Reset (rst_n=0, async): valid_o=0, data_o=0, ctrl_o=CTRL_RST, count_o=0, skid empty, ready_o=1 once rst_n released.
- ctrl_o = valid_o ? ctrl_q : CTRL_RST (output mask; bubbles never write the register file or memory).
- flush_i has highest priority: next cycle all entries invalid, count_o=0; beat offered in the flush cycle is dropped even if ready_o=1; data registers keep old contents.
- Main register (out) update, no flush: if out empty or transfer out: load skid if skid valid, else load input if transfer in, else go empty. Otherwise hold.
- Skid register: loaded with input when transfer in while out valid and not ready_i; cleared when its contents move to out.
- Simultaneous in and out with one entry held: out replaced by new beat, count stays 1, no bubble.
- Beats leave in exactly arrival order; no beat duplicated or lost except by flush.

## Timing
- Latency: 1 cycle valid_i -> valid_o when empty or draining.
- Throughput: 1 beat/cycle sustained with ready_i=1.
- Skid mode: ready_o = ~skid_valid, purely registered; stage absorbs one beat after ready_i falls; ready_o drops the cycle after the skid fills and rises the cycle after it drains.
- Non-skid mode: ready_o = ~valid_o | ready_i (combinational from ready_i).
- valid_o, data_o, count_o are registered; ctrl_o is one AND/mux level after ctrl_q.
- Reset mid-transfer: both entries discarded immediately, no output glitch to valid_o=1.

## Configuration
- CORE_PIPE_STAGE_SKID_EN defined: skid register present, registered ready_o, count_o reaches 2.
- Not defined: single register, combinational ready_o, count_o in {0,1}, skid logic and storage absent; handshake semantics otherwise identical.

## Structure
- Shared package/defines: default widths (`OPERAND_WIDTH`, `CPU_PC_SIZE`), per-stage CTRL_WIDTH constants and CTRL_RST bubble encodings.
- One sub-module: core_pipe_slot (valid + data + ctrl register with async active-low reset and load enable), instantiated as out slot and, under the macro, skid slot.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 entries held -> immediately valid_o=0, ctrl_o=CTRL_RST, count_o=0; after release ready_o=1.
- Streaming: 8 beats data=1..8, ready_i=1 -> data_o=1..8 on consecutive cycles, each one cycle after input, count_o=1.
- Back-pressure (skid on): beats A,B,C, ready_i=0 from the cycle A appears at output -> B captured in skid, count_o=2, ready_o=0, C held upstream; ready_i=1 -> A,B,C out in order with no gap.
- Flush: count_o=2, flush_i=1 with valid_i=1 beat D -> next cycle valid_o=0, ctrl_o=CTRL_RST, count_o=0, D never appears.
- Bubble mask: ctrl_i=3'b111 then valid_i=0 drained -> ctrl_o=CTRL_RST whenever valid_o=0 although ctrl_q=3'b111.
- Non-skid build: ready_i=0 with out valid -> ready_o=0 same cycle; ready_i=1 with valid_i=1 -> simultaneous in/out, count_o stays 1.
